// File: rtl/mdu_sequencer.sv
// Iterative RV32 M-extension unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, with a stall/done handshake toward the execute stage.
//
// state | meaning
// IDLE  | accepting start; divide corner cases go straight to DONE
// CALC  | iterating, one product/quotient bit per cycle (cnt 31 -> 0)
// DONE  | result held while hazard_stall is high
module mdu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hazard_stall,
  input  logic        flush,
  output logic [31:0] result,
  output logic        done,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  logic        accept;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_res;

  logic [32:0] mul_sum;
  logic [63:0] prod_nxt;
  logic [63:0] prod_fin;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [31:0] quo_nxt;
  logic [31:0] rem_nxt;
  logic [31:0] mul_res;
  logic [31:0] div_res;
  logic [31:0] calc_res;

  assign accept = (state == S_IDLE) && start && !flush;
  assign stall  = accept || (state == S_CALC);
  assign done   = (state == S_DONE);

  // Signedness per funct3: MUL/MULH both signed, MULHSU only a, DIV/REM both signed.
  assign sign_a = a[31] & (op[2] ? ~op[0] : (op[1:0] != 2'd3));
  assign sign_b = b[31] & (op[2] ? ~op[0] : ~op[1]);
  assign abs_a  = sign_a ? -a : a;
  assign abs_b  = sign_b ? -b : b;

  assign div_zero    = op[2] && (b == 32'd0);
  assign div_ovf     = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign special_res = div_zero ? (op[1] ? a : 32'hFFFF_FFFF)
                                : (op[1] ? 32'd0 : 32'h8000_0000);

  // Multiplier lives in prod[31:0] and is consumed LSB first as the partial sum shifts in.
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
  assign prod_nxt = {mul_sum, prod[31:1]};

  assign div_shift = {rem, quo[31]};
  assign div_ok    = div_shift >= {1'b0, mag_b};
  assign div_diff  = div_shift[31:0] - mag_b;
  assign rem_nxt   = div_ok ? div_diff : div_shift[31:0];
  assign quo_nxt   = {quo[30:0], div_ok};

  assign prod_fin = neg_q ? -prod_nxt : prod_nxt;
  assign mul_res  = (op_q[1:0] == 2'd0) ? prod_fin[31:0] : prod_fin[63:32];
  assign div_res  = op_q[1] ? (neg_q ? -rem_nxt : rem_nxt)
                            : (neg_q ? -quo_nxt : quo_nxt);
  assign calc_res = op_q[2] ? div_res : mul_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      op_q   <= 3'd0;
      neg_q  <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      prod   <= 64'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      result <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op;
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg_q <= (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
            prod  <= {32'd0, abs_b};
            quo   <= abs_a;
            rem   <= 32'd0;
            cnt   <= 5'd31;
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          prod <= prod_nxt;
          quo  <= quo_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - 5'd1;
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == 5'd0) begin
            result <= calc_res;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || !hazard_stall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against a 64-bit arithmetic model
// of the M-extension results and the cycle-level handshake.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hazard_stall;
  logic        flush;
  logic [31:0] result;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  mdu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .a            (a),
    .b            (b),
    .hazard_stall (hazard_stall),
    .flush        (flush),
    .result       (result),
    .done         (done),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          xs, ys, yz;
    longint unsigned xu, yu;
    logic [63:0]     p;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    yz = {32'd0, y};
    xu = {32'd0, x};
    yu = {32'd0, y};
    p  = 64'd0;
    case (o)
      3'd0: begin p = xs * ys; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yz; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = xs / ys; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = xu / yu; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        p = xs % ys; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = xu % yu; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Entered and left at a negedge with the FSM in IDLE; the next op may start immediately.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r, input int lat,
                        input int hold);
    start = 1'b1; op = o; a = x; b = y; hazard_stall = 1'($urandom);
    #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
        hazard_stall = 1'($urandom);
        #1 check({tag, "_busy"}, 32'({done, stall}), 32'd1);
      end
    end
    start = 1'b0;
    hazard_stall = (hold > 0);
    #1;
    check({tag, "_done"}, 32'({done, stall}), 32'd2);
    check({tag, "_result"}, result, exp_r);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      hazard_stall = (h < hold);
      #1;
      check({tag, "_hold_done"}, 32'(done), 32'd1);
      check({tag, "_hold_result"}, result, exp_r);
    end
    hazard_stall = 1'b0;
    @(negedge clk);
    #1 check({tag, "_idle"}, 32'({done, stall}), 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        seen_done;

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    hazard_stall = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_flags", 32'({done, stall}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("post_release_flags", 32'({done, stall}), 32'd0);

    run_op("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
    run_op("divu",       3'd5, 32'd100,        32'd7,         32'd14,        33, 0);
    run_op("remu",       3'd7, 32'd100,        32'd7,         32'd2,         33, 0);
    run_op("div_neg",    3'd4, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 33, 0);
    run_op("rem_neg",    3'd6, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33, 0);
    run_op("div_zero",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_zero",   3'd6, 32'd5,          32'd0,         32'd5,         1,  0);
    run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  3);
    run_op("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 3);
    run_op("b2b",        3'd0, 32'd3,          32'd5,         32'd15,        33, 0);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      ra = rand_operand();
      rb = rand_operand();
      run_op("rand", ro, ra, rb, ref_result(ro, ra, rb), ref_latency(ro, ra, rb),
             $urandom_range(0, 2));
    end

    // Flush mid-calculation at T+10.
    start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_calc_stall", 32'(stall), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_idle", 32'({done, stall}), 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", 32'(seen_done), 32'd0);

    // Start coincident with flush in IDLE is dropped.
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    #1 check("flush_start_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_start_ignored", 32'({done, stall}), 32'd0);

    // Flush out of DONE while hazard_stall is holding it; result keeps its value.
    start = 1'b1; op = 3'd4; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; hazard_stall = 1'b1;
    #1 check("flush_done_entry", 32'(done), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; hazard_stall = 1'b0;
    #1;
    check("flush_done_exit", 32'({done, stall}), 32'd0);
    check("flush_done_result_held", result, 32'hFFFF_FFFF);

    // Reset at T+20 mid-calculation.
    start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_calc_flags", 32'({done, stall}), 32'd0);
    check("reset_calc_result", result, 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("reset_calc_no_done", 32'(seen_done), 32'd0);

    // Reset in DONE overrides a coincident start and flush.
    start = 1'b1; op = 3'd6; a = 32'd9; b = 32'd0;
    @(negedge clk);
    hazard_stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    #1 check("reset_done_entry", result, 32'd9);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; flush = 1'b0; hazard_stall = 1'b0;
    #1;
    check("reset_done_flags", 32'({done, stall}), 32'd0);
    check("reset_done_result", result, 32'd0);

    run_op("recover", 3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
REQ-002 start  in  1  Execute holds a valid M-extension instruction.
REQ-003 op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-004 a  in  32  rs1 operand.
REQ-005 b  in  32  rs2 operand.
REQ-006 hazard_stall  in  1  downstream pipeline stall; execute cannot advance.
REQ-007 flush  in  1  kill the in-flight instruction (branch mispredict).
REQ-008 result  out  32  M-extension result.
REQ-009 done  out  1  result is valid this cycle.
REQ-010 stall  out  1  freeze the pipeline at and before execute.

Function
REQ-011 The FSM SHALL have exactly three states:
- IDLE: accepting start.
- CALC: iterating.
- DONE: result held.
REQ-012 Operand capture SHALL work as follows:
- In IDLE with start=1, a, b and op are registered at that edge (cycle T).
- a, b and op are ignored until the FSM returns to IDLE.
REQ-013 stall SHALL be combinational: 1 when (IDLE and start and not flush) or CALC, else 0.
REQ-014 Normal path latency SHALL be:
- IDLE -> CALC at T+1.
- CALC runs exactly 32 cycles (5-bit counter 31 down to 0).
- CALC -> DONE at T+33.
REQ-015 A special case (REQ-020/021) SHALL bypass CALC: IDLE -> DONE at T+1.
REQ-016 In DONE, done=1, stall=0 and result is stable. The state SHALL:
- stay in DONE while hazard_stall=1;
- go to IDLE at the next edge when hazard_stall=0.
REQ-017 A start in the cycle the FSM enters IDLE from DONE SHALL belong to the next instruction and be accepted normally; back-to-back ops have no bubble beyond the compute latency.
REQ-018 Multiply SHALL use unsigned shift-add on 32-bit magnitudes into a 64-bit product, one bit per CALC cycle, with sign rules:
- MUL and MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- MULHU: both unsigned.
- Final negation when the operand signs differ.
- MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-019 Divide SHALL use restoring division on magnitudes, one quotient bit per cycle, with sign rules:
- DIV and REM are signed; DIVU and REMU are unsigned.
- Quotient is negated when the signs differ.
- Remainder takes the sign of the dividend.
REQ-020 Divide-by-zero (b=0) SHALL return:
- DIV and DIVU: 0xFFFFFFFF.
- REM and REMU: a.
REQ-021 Signed overflow (DIV or REM, a=0x80000000, b=0xFFFFFFFF) SHALL return:
- DIV: 0x80000000.
- REM: 0x00000000.
REQ-022 flush=1 SHALL force IDLE at the next edge from any state:
- Partial results are discarded and done=0 next cycle.
- A start coincident with flush in IDLE is not accepted.
REQ-023 hazard_stall SHALL have no effect in IDLE or CALC; CALC continues counting.
REQ-024 result SHALL hold its last value outside DONE; consumers use it only when done=1.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force the following, overriding start and flush, including mid-CALC and mid-DONE:
- state=IDLE, counter=0, result=0.
- Working product, quotient and remainder registers cleared.
REQ-026 In the first cycle after reset is released, done=0, and stall=0 unless start=1.

Verification
REQ-027 MUL, a=7, b=0xFFFFFFFD:
- stall=1 for T..T+32.
- At T+33: done=1, result=0xFFFFFFEB, stall=0.
REQ-028 MULH, a=b=0x80000000 -> result=0x40000000 at T+33.
REQ-029 MULHU, a=b=0xFFFFFFFF -> result=0xFFFFFFFE at T+33.
REQ-030 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIV 0xFFFFFF9C/7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; all at T+33.
REQ-031 Special cases, DONE at T+1:
- DIV a=5, b=0 -> 0xFFFFFFFF.
- REM a=5, b=0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-032 Hazard hold:
- hazard_stall=1 for 3 cycles after DONE -> done and result held for 4 cycles, then IDLE.
- A new start in the following cycle is accepted with no bubble.
REQ-033 Flush and reset:
- flush at T+10 -> IDLE at T+11, done never asserted, stall=0.
- rst_n=0 at T+20 -> IDLE, result=0.
